// File: rtl/led_pattern_pkg.sv
// Shared encodings, constants and helpers for the LED pattern monitor.
package led_pattern_pkg;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_SCAN  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] PAT_AA    = 8'hAA;
  localparam logic [7:0] PAT_55    = 8'h55;
  localparam logic [3:0] CAND_ALL  = 4'b1111;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  // Feedback bit of the generator's shift register: parity over the tapped bits.
  function automatic logic lfsr_feedback(input logic [7:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] cand_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = MODE_COUNT;
      4'b0010: idx = MODE_SCAN;
      4'b0100: idx = MODE_LFSR;
      4'b1000: idx = MODE_ALT;
      default: idx = MODE_COUNT;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/led_pattern_match.sv
// Combinational classifier: which known patterns explain the step prev -> cur.
module led_pattern_match
  import led_pattern_pkg::*;
(
  input  logic [7:0] prev,
  input  logic [7:0] cur,
  output logic [3:0] match
);

  logic [7:0] prev_inc_s;
  logic [7:0] lfsr_next_s;
  logic       scan_s;
  logic       alt_s;

  assign prev_inc_s  = prev + 8'd1;
  assign lfsr_next_s = {prev[6:0], lfsr_feedback(prev)};
  assign scan_s      = is_onehot8(prev) && is_onehot8(cur) &&
                       ((cur == (prev << 1)) || (cur == (prev >> 1)));
  assign alt_s       = ((prev == PAT_AA) && (cur == PAT_55)) ||
                       ((prev == PAT_55) && (cur == PAT_AA));

  assign match = {alt_s, (cur == lfsr_next_s), scan_s, (cur == prev_inc_s)};

endmodule

// File: rtl/led_pattern_monitor.sv
// Identifies which LED pattern a generator is producing, locks onto it and flags violations and stalls.
module led_pattern_monitor
  import led_pattern_pkg::*;
#(
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] led_in,
  output logic [1:0] mode,
  output logic       locked,
  output logic       mismatch,
  output logic       stale,
  output logic [3:0] cand
);

  localparam int              IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
  localparam logic [3:0]      LOCK_RUN = 4'(LOCK_COUNT);

  state_t            state_r, state_s;
  logic [7:0]        cur_r, prev_r, prev_s;
  logic              prev_valid_r;
  logic [3:0]        cand_r, cand_s;
  logic [3:0]        run_r, run_s;
  logic [IDLE_W-1:0] idle_r, idle_s;
  logic [1:0]        mode_r, mode_s;
  logic              locked_r, locked_s;
  logic              mismatch_r, mismatch_s;
  logic              stale_r, stale_s;
  logic [3:0]        match_s, hit_s, acq_cand_s;
  logic [3:0]        acq_run_s;
  logic              change_s;

  led_pattern_match u_match (
    .prev  (prev_r),
    .cur   (cur_r),
    .match (match_s)
  );

  assign change_s = (cur_r != prev_r);

  // prev follows the raw bus until the monitor is enabled and primed, then trails cur.
  always_comb begin
    if (enable && prev_valid_r) begin
      prev_s = cur_r;
    end else begin
      prev_s = led_in;
    end
  end

  // Next-state and output decode of the ACQUIRE/LOCKED machine plus idle tracking.
  always_comb begin
    state_s    = state_r;
    cand_s     = cand_r;
    run_s      = run_r;
    idle_s     = idle_r;
    mode_s     = mode_r;
    locked_s   = locked_r;
    stale_s    = stale_r;
    mismatch_s = 1'b0;

    hit_s = cand_r & match_s;
    if (hit_s != 4'd0) begin
      acq_cand_s = hit_s;
      acq_run_s  = (run_r == 4'd15) ? 4'd15 : (run_r + 4'd1);
    end else if (match_s != 4'd0) begin
      acq_cand_s = match_s;
      acq_run_s  = 4'd1;
    end else begin
      acq_cand_s = CAND_ALL;
      acq_run_s  = 4'd0;
    end

    if (!enable) begin
      state_s  = ST_ACQUIRE;
      cand_s   = CAND_ALL;
      run_s    = 4'd0;
      idle_s   = '0;
      locked_s = 1'b0;
      stale_s  = 1'b0;
    end else if (!prev_valid_r) begin
      idle_s = idle_r;
    end else if (change_s) begin
      idle_s  = '0;
      stale_s = 1'b0;
      case (state_r)
        ST_ACQUIRE: begin
          cand_s = acq_cand_s;
          run_s  = acq_run_s;
          if (is_onehot4(acq_cand_s) && (acq_run_s >= LOCK_RUN)) begin
            state_s  = ST_LOCKED;
            locked_s = 1'b1;
            mode_s   = cand_index(acq_cand_s);
          end else begin
            state_s = ST_ACQUIRE;
          end
        end
        ST_LOCKED: begin
          if (match_s[mode_r]) begin
            state_s = ST_LOCKED;
          end else begin
            mismatch_s = 1'b1;
            locked_s   = 1'b0;
            state_s    = ST_ACQUIRE;
            cand_s     = (match_s != 4'd0) ? match_s : CAND_ALL;
            run_s      = (match_s != 4'd0) ? 4'd1 : 4'd0;
          end
        end
        default: begin
          state_s  = ST_ACQUIRE;
          cand_s   = CAND_ALL;
          run_s    = 4'd0;
          locked_s = 1'b0;
        end
      endcase
    end else begin
      idle_s = (idle_r == IDLE_MAX) ? IDLE_MAX : (idle_r + IDLE_ONE);
      // A stalled generator invalidates any lock; restart acquisition from scratch.
      if (idle_s == IDLE_MAX) begin
        stale_s  = 1'b1;
        state_s  = ST_ACQUIRE;
        locked_s = 1'b0;
        cand_s   = CAND_ALL;
        run_s    = 4'd0;
      end else begin
        stale_s = stale_r;
      end
    end
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_ACQUIRE;
      cur_r        <= 8'd0;
      prev_r       <= 8'd0;
      prev_valid_r <= 1'b0;
      cand_r       <= CAND_ALL;
      run_r        <= 4'd0;
      idle_r       <= '0;
      mode_r       <= MODE_COUNT;
      locked_r     <= 1'b0;
      mismatch_r   <= 1'b0;
      stale_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      cur_r        <= led_in;
      prev_r       <= prev_s;
      prev_valid_r <= enable;
      cand_r       <= cand_s;
      run_r        <= run_s;
      idle_r       <= idle_s;
      mode_r       <= mode_s;
      locked_r     <= locked_s;
      mismatch_r   <= mismatch_s;
      stale_r      <= stale_s;
    end
  end

  assign mode     = mode_r;
  assign locked   = locked_r;
  assign mismatch = mismatch_r;
  assign stale    = stale_r;
  assign cand     = cand_r;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Directed bench for led_pattern_monitor: lock on each pattern, mismatch, stale, enable and reset.
module tb_led_pattern_monitor;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] led_in;
  logic [1:0] mode;
  logic       locked;
  logic       mismatch;
  logic       stale;
  logic [3:0] cand;

  int n_cmp;
  int n_bad;

  led_pattern_monitor #(.LOCK_COUNT(4), .TIMEOUT_CYCLES(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .led_in   (led_in),
    .mode     (mode),
    .locked   (locked),
    .mismatch (mismatch),
    .stale    (stale),
    .cand     (cand)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Park with enable low on the first value, then enable and let prev prime.
  task automatic start_seq(input logic [7:0] v);
    enable = 1'b0;
    led_in = v;
    step(2);
    enable = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL reset_mismatch: got %b expected 0", mismatch); end
    n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL reset_stale: got %b expected 0", stale); end
    n_cmp++; if (cand !== 4'b1111) begin n_bad++; $display("FAIL reset_cand: got %b expected 1111", cand); end
  endtask

  task automatic test_count_lock_and_jump;
    start_seq(8'h10);
    led_in = 8'h11; step(8);
    led_in = 8'h12; step(8);
    led_in = 8'h13; step(8);
    led_in = 8'h14; step(1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL count_latency: got locked=%b expected 0", locked); end
    step(1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL count_locked: got %b expected 1", locked); end
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL count_mode: got %0d expected 0", mode); end
    n_cmp++; if (cand !== 4'b0001) begin n_bad++; $display("FAIL count_cand: got %b expected 0001", cand); end
    // 0x14 -> 0x80 fits no pattern at all
    led_in = 8'h80; step(2);
    n_cmp++; if (mismatch !== 1'b1) begin n_bad++; $display("FAIL jump_mismatch: got %b expected 1", mismatch); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL jump_locked: got %b expected 0", locked); end
    n_cmp++; if (cand !== 4'b1111) begin n_bad++; $display("FAIL jump_cand: got %b expected 1111", cand); end
    step(1);
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL jump_pulse_width: got %b expected 0", mismatch); end
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL jump_mode_hold: got %0d expected 0", mode); end
  endtask

  task automatic test_scan;
    logic [7:0] bounce [4];
    bounce[0] = 8'h20; bounce[1] = 8'h40; bounce[2] = 8'h80; bounce[3] = 8'h40;
    start_seq(8'h01);
    led_in = 8'h02; step(8);
    led_in = 8'h04; step(8);
    led_in = 8'h08; step(8);
    led_in = 8'h10; step(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL scan_locked: got %b expected 1", locked); end
    n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL scan_mode: got %0d expected 1", mode); end
    step(6);
    for (int i = 0; i < 4; i++) begin
      led_in = bounce[i]; step(2);
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL scan_hold_locked[%0d]: got %b expected 1", i, locked); end
      n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL scan_hold_mismatch[%0d]: got %b expected 0", i, mismatch); end
      step(6);
    end
  endtask

  task automatic test_alt;
    start_seq(8'hAA);
    led_in = 8'h55; step(2);
    n_cmp++; if (cand !== 4'b1100) begin n_bad++; $display("FAIL alt_cand1: got %b expected 1100", cand); end
    step(6);
    led_in = 8'hAA; step(2);
    n_cmp++; if (cand !== 4'b1000) begin n_bad++; $display("FAIL alt_cand2: got %b expected 1000", cand); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL alt_early_lock: got %b expected 0", locked); end
    step(6);
    led_in = 8'h55; step(8);
    led_in = 8'hAA; step(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL alt_locked: got %b expected 1", locked); end
    n_cmp++; if (mode !== 2'd3) begin n_bad++; $display("FAIL alt_mode: got %0d expected 3", mode); end
  endtask

  task automatic test_mismatch_to_scan;
    start_seq(8'h04);
    led_in = 8'h05; step(8);
    led_in = 8'h06; step(8);
    led_in = 8'h07; step(8);
    led_in = 8'h08; step(2);
    n_cmp++; if (locked !== 1'b1 || mode !== 2'd0) begin n_bad++; $display("FAIL mm_lock: got locked=%b mode=%0d expected 1/0", locked, mode); end
    step(6);
    // 0x08 -> 0x10 is a scanner step only (LFSR would give 0x11)
    led_in = 8'h10; step(2);
    n_cmp++; if (mismatch !== 1'b1) begin n_bad++; $display("FAIL mm_pulse: got %b expected 1", mismatch); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mm_locked: got %b expected 0", locked); end
    n_cmp++; if (cand !== 4'b0010) begin n_bad++; $display("FAIL mm_cand: got %b expected 0010", cand); end
    step(1);
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL mm_pulse_width: got %b expected 0", mismatch); end
  endtask

  task automatic test_enable;
    start_seq(8'h01);
    led_in = 8'h02; step(8);
    led_in = 8'h04; step(8);
    led_in = 8'h08; step(8);
    led_in = 8'h10; step(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL en_pre_locked: got %b expected 1", locked); end
    enable = 1'b0; led_in = 8'h77; step(1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL en_locked: got %b expected 0", locked); end
    n_cmp++; if (cand !== 4'b1111) begin n_bad++; $display("FAIL en_cand: got %b expected 1111", cand); end
    n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL en_mode_hold: got %0d expected 1", mode); end
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL en_mismatch: got %b expected 0", mismatch); end
  endtask

  task automatic test_stale;
    start_seq(8'h10);
    led_in = 8'h11; step(8);
    led_in = 8'h12; step(8);
    led_in = 8'h13; step(8);
    led_in = 8'h14; step(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL stale_pre_locked: got %b expected 1", locked); end
    step(15);
    n_cmp++; if (stale !== 1'b0 || locked !== 1'b1) begin n_bad++; $display("FAIL stale_early: got stale=%b locked=%b expected 0/1", stale, locked); end
    step(1);
    n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL stale_set: got %b expected 1", stale); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL stale_locked: got %b expected 0", locked); end
    n_cmp++; if (cand !== 4'b1111) begin n_bad++; $display("FAIL stale_cand: got %b expected 1111", cand); end
    step(3);
    n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL stale_hold: got %b expected 1", stale); end
    led_in = 8'h15; step(2);
    n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL stale_clear: got %b expected 0", stale); end
    n_cmp++; if (cand !== 4'b0001) begin n_bad++; $display("FAIL stale_reacquire_cand: got %b expected 0001", cand); end
  endtask

  task automatic test_reset_mid_lock;
    start_seq(8'hAA);
    led_in = 8'h55; step(8);
    led_in = 8'hAA; step(8);
    led_in = 8'h55; step(8);
    led_in = 8'hAA; step(2);
    n_cmp++; if (locked !== 1'b1 || mode !== 2'd3) begin n_bad++; $display("FAIL rst_pre_lock: got locked=%b mode=%0d expected 1/3", locked, mode); end
    led_in = 8'h55; step(1);
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_async_locked: got %b expected 0", locked); end
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL rst_async_mode: got %0d expected 0", mode); end
    n_cmp++; if (mismatch !== 1'b0 || stale !== 1'b0) begin n_bad++; $display("FAIL rst_async_flags: got mismatch=%b stale=%b expected 0/0", mismatch, stale); end
    n_cmp++; if (cand !== 4'b1111) begin n_bad++; $display("FAIL rst_async_cand: got %b expected 1111", cand); end
    led_in = 8'h33; step(2);
    reset = 1'b0;
    step(1);
    led_in = 8'h34; step(1);
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL rst_post_mismatch0: got %b expected 0", mismatch); end
    step(1);
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL rst_post_mismatch1: got %b expected 0", mismatch); end
    n_cmp++; if (cand !== 4'b0001 || locked !== 1'b0) begin n_bad++; $display("FAIL rst_post_acquire: got cand=%b locked=%b expected 0001/0", cand, locked); end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    enable = 1'b0;
    led_in = 8'h00;
    #1;
    test_reset();
    #13 reset = 1'b0;
    step(1);
    test_count_lock_and_jump();
    test_scan();
    test_alt();
    test_mismatch_to_scan();
    test_enable();
    test_stale();
    test_reset_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
